// File: rtl/osc_phase_accumulator_if.sv
// Tuning handshake, control strobes and sample outputs of the oscillator phase accumulator.
// The master drives tick/tune/sync/wave_sel; the slave returns phase, wrap and samples.
interface osc_phase_accumulator_if #(
  parameter int WIDTH     = 17,
  parameter int OUT_WIDTH = 16
);
  logic                 sample_tick;
  logic [WIDTH-1:0]     tune_word;
  logic                 tune_valid;
  logic                 tune_ready;
  logic [1:0]           wave_sel;
  logic                 hard_sync;
  logic [WIDTH-1:0]     phase;
  logic                 wrap;
  logic [OUT_WIDTH-1:0] sample_out;
  logic                 sample_valid;

  modport master (
    output sample_tick, tune_word, tune_valid, wave_sel, hard_sync,
    input  tune_ready, phase, wrap, sample_out, sample_valid
  );

  modport slave (
    input  sample_tick, tune_word, tune_valid, wave_sel, hard_sync,
    output tune_ready, phase, wrap, sample_out, sample_valid
  );
endinterface

// File: rtl/osc_phase_accumulator.sv
// Phase accumulator with glitch-free retuning (new word waits for the next wrap)
// and a registered saw/square/triangle output stage.
module osc_phase_accumulator #(
  parameter int WIDTH     = 17,
  parameter int OUT_WIDTH = 16
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  osc_phase_accumulator_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, PENDING} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     phase_q, phase_d;
  logic [WIDTH-1:0]     word_q, word_d;
  logic [WIDTH-1:0]     pend_q, pend_d;
  logic                 wrap_q, wrap_d;
  logic                 upd_q, upd_d;
  logic [OUT_WIDTH-1:0] sample_q, sample_d;
  logic                 svalid_q, svalid_d;
  logic                 ready;
  logic                 accept;
  logic                 carry;
  logic [WIDTH-1:0]     sum;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      word_q   <= '0;
      pend_q   <= '0;
      wrap_q   <= 1'b0;
      upd_q    <= 1'b0;
      sample_q <= '0;
      svalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      word_q   <= word_d;
      pend_q   <= pend_d;
      wrap_q   <= wrap_d;
      upd_q    <= upd_d;
      sample_q <= sample_d;
      svalid_q <= svalid_d;
    end
  end

  always_comb begin
    {carry, sum} = {1'b0, phase_q} + {1'b0, word_q};
    state_d  = state_q;
    phase_d  = phase_q;
    word_d   = word_q;
    pend_d   = pend_q;
    wrap_d   = 1'b0;
    upd_d    = bus.sample_tick | bus.hard_sync;
    ready    = (state_q != PENDING) && !bus.hard_sync;
    accept   = bus.tune_valid && ready;
    sample_d = sample_q;
    svalid_d = upd_q;

    if (bus.hard_sync) begin
      phase_d = '0;
      if (state_q == PENDING) begin
        word_d  = pend_q;
        state_d = (pend_q == '0) ? IDLE : RUN;
      end
    end else begin
      case (state_q)
        IDLE: begin
          // Ticks are ignored here; phase stays parked at zero.
          if (accept && (bus.tune_word != '0)) begin
            word_d  = bus.tune_word;
            state_d = RUN;
          end
        end
        RUN: begin
          if (bus.sample_tick) begin
            phase_d = sum;
            wrap_d  = carry;
          end
          if (accept) begin
            pend_d  = bus.tune_word;
            state_d = PENDING;
          end
        end
        PENDING: begin
          if (bus.sample_tick) begin
            phase_d = sum;
            wrap_d  = carry;
            // Swap words only at the wrap so the waveform period never glitches.
            if (carry) begin
              word_d = pend_q;
              if (pend_q == '0) begin
                state_d = IDLE;
                phase_d = '0;
              end else begin
                state_d = RUN;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (upd_q) begin
      case (bus.wave_sel)
        2'b00:   sample_d = phase_q[WIDTH-1:1];
        2'b01:   sample_d = phase_q[WIDTH-1] ? {OUT_WIDTH{1'b1}} : '0;
        2'b10:   sample_d = phase_q[WIDTH-1] ? ~phase_q[WIDTH-2:0] : phase_q[WIDTH-2:0];
        default: sample_d = '0;
      endcase
    end
  end

  assign bus.tune_ready   = ready;
  assign bus.phase        = phase_q;
  assign bus.wrap         = wrap_q;
  assign bus.sample_out   = sample_q;
  assign bus.sample_valid = svalid_q;

endmodule

// File: tb/tb_osc_phase_accumulator.sv
// Directed and randomized checks of osc_phase_accumulator against an arithmetic reference model.
module tb_osc_phase_accumulator;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  osc_phase_accumulator_if #(.WIDTH(17), .OUT_WIDTH(16)) bus();
  osc_phase_accumulator #(.WIDTH(17), .OUT_WIDTH(16)) dut (
    .clock_i (clock),
    .reset_i (reset),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain integer arithmetic on phase, word and a pending slot.
  int   m_phase, m_word, m_pend, m_sample;
  bit   m_has_pend, m_wrap, m_svalid, m_upd;
  logic obs_ready;
  bit   exp_ready;

  function automatic int wave(int ph, logic [1:0] sel);
    case (sel)
      2'b00:   return ph / 2;
      2'b01:   return (ph >= 65536) ? 65535 : 0;
      2'b10:   return (ph >= 65536) ? 65535 - (ph - 65536) : ph;
      default: return 0;
    endcase
  endfunction

  task automatic model_step(bit rst, bit tick, bit valid, int word, logic [1:0] sel, bit sync);
    bit ready_now;
    bit loaded;
    int total;
    ready_now = !m_has_pend && !sync;
    loaded    = (m_word != 0);
    m_svalid  = m_upd;
    if (m_upd) m_sample = wave(m_phase, sel);
    m_upd  = tick || sync;
    m_wrap = 1'b0;
    if (rst) begin
      m_phase = 0; m_word = 0; m_pend = 0; m_has_pend = 0;
      m_sample = 0; m_svalid = 0; m_upd = 0;
      return;
    end
    if (sync) begin
      m_phase = 0;
      if (m_has_pend) begin m_word = m_pend; m_has_pend = 0; end
      return;
    end
    if (tick && loaded) begin
      total   = m_phase + m_word;
      m_wrap  = (total >= 131072);
      m_phase = total % 131072;
      if (m_wrap && m_has_pend) begin
        m_word = m_pend; m_has_pend = 0;
        if (m_word == 0) m_phase = 0;
      end
    end
    if (valid && ready_now) begin
      if (!loaded) m_word = word;
      else begin m_pend = word; m_has_pend = 1; end
    end
  endtask

  task automatic cyc(bit rst, bit tick, bit valid, logic [16:0] word, logic [1:0] sel, bit sync);
    reset = rst;
    bus.sample_tick = tick;
    bus.tune_valid  = valid;
    bus.tune_word   = word;
    bus.wave_sel    = sel;
    bus.hard_sync   = sync;
    @(negedge clock);
    obs_ready = bus.tune_ready;
    exp_ready = !m_has_pend && !sync;
    @(posedge clock);
    #1;
    model_step(rst, tick, valid, int'(word), sel, sync);
  endtask

  task automatic idle(logic [1:0] sel);               cyc(0, 0, 0, 17'h0, sel, 0); endtask
  task automatic tk(logic [1:0] sel);                 cyc(0, 1, 0, 17'h0, sel, 0); endtask
  task automatic load(logic [16:0] w, logic [1:0] s); cyc(0, 0, 1, w, s, 0);       endtask
  task automatic do_reset();                          cyc(1, 0, 0, 17'h0, 2'b00, 0); endtask

  task automatic test_reset();
    do_reset(); do_reset(); do_reset();
    n_checks++; if (bus.phase !== 17'h0) begin n_fail++; $display("FAIL reset_phase got=%h exp=0", bus.phase); end
    n_checks++; if (bus.wrap !== 1'b0) begin n_fail++; $display("FAIL reset_wrap got=%b exp=0", bus.wrap); end
    n_checks++; if (bus.sample_out !== 16'h0) begin n_fail++; $display("FAIL reset_sample got=%h exp=0", bus.sample_out); end
    n_checks++; if (bus.sample_valid !== 1'b0) begin n_fail++; $display("FAIL reset_svalid got=%b exp=0", bus.sample_valid); end
    idle(2'b00);
    n_checks++; if (obs_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", obs_ready); end
    $display("test_reset done");
  endtask

  task automatic test_saw();
    load(17'h00100, 2'b00);
    n_checks++; if (bus.phase !== 17'h0) begin n_fail++; $display("FAIL saw_load_phase got=%h exp=0", bus.phase); end
    for (int i = 0; i < 4; i++) begin
      tk(2'b00);
      n_checks++; if (bus.phase !== 17'(32'h100 * (i + 1))) begin n_fail++; $display("FAIL saw_phase[%0d] got=%h exp=%h", i, bus.phase, 32'h100 * (i + 1)); end
      n_checks++; if (bus.wrap !== 1'b0) begin n_fail++; $display("FAIL saw_wrap[%0d] got=%b exp=0", i, bus.wrap); end
      if (i > 0) begin
        n_checks++; if (bus.sample_valid !== 1'b1 || bus.sample_out !== 16'(32'h80 * i)) begin n_fail++; $display("FAIL saw_sample[%0d] got=%b/%h exp=1/%h", i, bus.sample_valid, bus.sample_out, 32'h80 * i); end
      end
    end
    idle(2'b00);
    n_checks++; if (bus.sample_valid !== 1'b1 || bus.sample_out !== 16'h0200) begin n_fail++; $display("FAIL saw_last_sample got=%b/%h exp=1/0200", bus.sample_valid, bus.sample_out); end
    idle(2'b00);
    n_checks++; if (bus.sample_valid !== 1'b0) begin n_fail++; $display("FAIL saw_valid_drop got=%b exp=0", bus.sample_valid); end
    $display("test_saw done");
  endtask

  task automatic test_square_wrap();
    logic [16:0] exp_ph [3] = '{17'h10000, 17'h00000, 17'h10000};
    logic        exp_wr [3] = '{1'b0, 1'b1, 1'b0};
    logic [15:0] exp_sq [3] = '{16'hFFFF, 16'h0000, 16'hFFFF};
    do_reset();
    load(17'h10000, 2'b01);
    for (int i = 0; i < 3; i++) begin
      tk(2'b01);
      n_checks++; if (bus.phase !== exp_ph[i] || bus.wrap !== exp_wr[i]) begin n_fail++; $display("FAIL sq_phase[%0d] got=%h/%b exp=%h/%b", i, bus.phase, bus.wrap, exp_ph[i], exp_wr[i]); end
      if (i > 0) begin
        n_checks++; if (bus.sample_out !== exp_sq[i-1]) begin n_fail++; $display("FAIL sq_sample[%0d] got=%h exp=%h", i - 1, bus.sample_out, exp_sq[i-1]); end
      end
    end
    idle(2'b01);
    n_checks++; if (bus.sample_out !== exp_sq[2]) begin n_fail++; $display("FAIL sq_sample[2] got=%h exp=%h", bus.sample_out, exp_sq[2]); end
    $display("test_square_wrap done");
  endtask

  task automatic test_retune();
    logic [16:0] exp_ph [3] = '{17'h10000, 17'h18000, 17'h00000};
    do_reset();
    load(17'h08000, 2'b00);
    cyc(0, 0, 1, 17'h04000, 2'b00, 0);
    n_checks++; if (obs_ready !== 1'b1) begin n_fail++; $display("FAIL retune_accept_ready got=%b exp=1", obs_ready); end
    cyc(0, 1, 1, 17'h01000, 2'b00, 0);
    n_checks++; if (obs_ready !== 1'b0) begin n_fail++; $display("FAIL retune_pending_ready got=%b exp=0", obs_ready); end
    n_checks++; if (bus.phase !== 17'h08000) begin n_fail++; $display("FAIL retune_old_step got=%h exp=08000", bus.phase); end
    for (int i = 0; i < 3; i++) begin
      tk(2'b00);
      n_checks++; if (bus.phase !== exp_ph[i] || bus.wrap !== (i == 2)) begin n_fail++; $display("FAIL retune_phase[%0d] got=%h/%b exp=%h/%b", i, bus.phase, bus.wrap, exp_ph[i], i == 2); end
    end
    tk(2'b00);
    n_checks++; if (obs_ready !== 1'b1) begin n_fail++; $display("FAIL retune_ready_back got=%b exp=1", obs_ready); end
    n_checks++; if (bus.phase !== 17'h04000 || bus.wrap !== 1'b0) begin n_fail++; $display("FAIL retune_new_step got=%h/%b exp=04000/0", bus.phase, bus.wrap); end
    $display("test_retune done");
  endtask

  task automatic test_hard_sync();
    do_reset();
    load(17'h0ABCD, 2'b00);
    tk(2'b00);
    n_checks++; if (bus.phase !== 17'h0ABCD) begin n_fail++; $display("FAIL sync_setup_phase got=%h exp=0abcd", bus.phase); end
    load(17'h00300, 2'b00);
    cyc(0, 1, 1, 17'h00777, 2'b00, 1);
    n_checks++; if (obs_ready !== 1'b0) begin n_fail++; $display("FAIL sync_ready got=%b exp=0", obs_ready); end
    n_checks++; if (bus.phase !== 17'h0 || bus.wrap !== 1'b0) begin n_fail++; $display("FAIL sync_phase got=%h/%b exp=0/0", bus.phase, bus.wrap); end
    tk(2'b00);
    n_checks++; if (bus.phase !== 17'h00300) begin n_fail++; $display("FAIL sync_pending_active got=%h exp=00300", bus.phase); end
    n_checks++; if (bus.sample_valid !== 1'b1 || bus.sample_out !== 16'h0) begin n_fail++; $display("FAIL sync_sample got=%b/%h exp=1/0000", bus.sample_valid, bus.sample_out); end
    tk(2'b00);
    n_checks++; if (obs_ready !== 1'b1 || bus.phase !== 17'h00600) begin n_fail++; $display("FAIL sync_no_accept got=%b/%h exp=1/00600", obs_ready, bus.phase); end
    $display("test_hard_sync done");
  endtask

  task automatic test_triangle();
    logic [15:0] exp_tri [3] = '{16'h8000, 16'hFFFF, 16'h7FFF};
    do_reset();
    load(17'h08000, 2'b10);
    tk(2'b10);
    for (int i = 0; i < 3; i++) begin
      tk(2'b10);
      n_checks++; if (bus.sample_valid !== 1'b1 || bus.sample_out !== exp_tri[i]) begin n_fail++; $display("FAIL tri_sample[%0d] got=%b/%h exp=1/%h", i, bus.sample_valid, bus.sample_out, exp_tri[i]); end
    end
    $display("test_triangle done");
  endtask

  task automatic test_reset_pending();
    do_reset();
    load(17'h08000, 2'b00);
    tk(2'b00);
    cyc(0, 0, 1, 17'h04000, 2'b00, 0);
    n_checks++; if (bus.sample_out !== 16'h4000) begin n_fail++; $display("FAIL rstp_pre_sample got=%h exp=4000", bus.sample_out); end
    do_reset();
    n_checks++; if (bus.phase !== 17'h0 || bus.wrap !== 1'b0 || bus.sample_out !== 16'h0 || bus.sample_valid !== 1'b0) begin n_fail++; $display("FAIL rstp_outputs got=%h/%b/%h/%b exp=0/0/0/0", bus.phase, bus.wrap, bus.sample_out, bus.sample_valid); end
    for (int i = 0; i < 3; i++) begin
      tk(2'b00);
      n_checks++; if (obs_ready !== 1'b1 || bus.phase !== 17'h0 || bus.wrap !== 1'b0) begin n_fail++; $display("FAIL rstp_idle[%0d] got=%b/%h/%b exp=1/0/0", i, obs_ready, bus.phase, bus.wrap); end
    end
    load(17'h00200, 2'b00);
    tk(2'b00);
    n_checks++; if (bus.phase !== 17'h00200) begin n_fail++; $display("FAIL rstp_reload got=%h exp=00200", bus.phase); end
    $display("test_reset_pending done");
  endtask

  task automatic test_random();
    bit          r, t, v, s;
    logic [16:0] w;
    logic [1:0]  sel;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      r   = ($urandom_range(0, 99) == 0);
      t   = ($urandom_range(0, 1) == 1);
      v   = ($urandom_range(0, 9) < 3);
      s   = ($urandom_range(0, 19) == 0);
      sel = 2'($urandom);
      case ($urandom_range(0, 7))
        0:       w = 17'h0;
        1:       w = 17'h10000 | 17'($urandom_range(0, 255));
        default: w = 17'($urandom);
      endcase
      cyc(r, t, v, w, sel, s);
      n_checks++; if (obs_ready !== exp_ready) begin n_fail++; $display("FAIL rand_ready[%0d] got=%b exp=%b", i, obs_ready, exp_ready); end
      n_checks++; if (bus.phase !== 17'(m_phase)) begin n_fail++; $display("FAIL rand_phase[%0d] got=%h exp=%h", i, bus.phase, 17'(m_phase)); end
      n_checks++; if (bus.wrap !== m_wrap) begin n_fail++; $display("FAIL rand_wrap[%0d] got=%b exp=%b", i, bus.wrap, m_wrap); end
      n_checks++; if (bus.sample_valid !== m_svalid) begin n_fail++; $display("FAIL rand_svalid[%0d] got=%b exp=%b", i, bus.sample_valid, m_svalid); end
      n_checks++; if (bus.sample_out !== 16'(m_sample)) begin n_fail++; $display("FAIL rand_sample[%0d] got=%h exp=%h", i, bus.sample_out, 16'(m_sample)); end
    end
    $display("test_random done");
  endtask

  initial begin
    bus.sample_tick = 1'b0;
    bus.tune_valid  = 1'b0;
    bus.tune_word   = '0;
    bus.wave_sel    = 2'b00;
    bus.hard_sync   = 1'b0;
    m_phase = 0; m_word = 0; m_pend = 0; m_sample = 0;
    m_has_pend = 0; m_wrap = 0; m_svalid = 0; m_upd = 0;
    test_reset();
    test_saw();
    test_square_wrap();
    test_retune();
    test_hard_sync();
    test_triangle();
    test_reset_pending();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
